// File: rtl/bin2bcd_pkg.sv
// Shared types and constants for the iterative double-dabble converter.
// Optional overflow/saturation support is enabled with BIN2BCD_OVF_EN.
package bin2bcd_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_e;

    localparam logic [3:0] ADD3_THRESH = 4'd4;
    localparam logic [3:0] ADD3_CORR   = 4'd3;
    localparam logic [3:0] BCD_NINE    = 4'h9;

    // Largest decimal value representable is pow10(DIGITS)-1.
    function automatic longint unsigned pow10(input int unsigned n);
        longint unsigned r;
        r = 64'd1;
        for (int unsigned i = 0; i < n; i++) begin
            r = r * 64'd10;
        end
        return r;
    endfunction

endpackage

// File: rtl/bin2bcd_add3.sv
// Combinational double-dabble digit corrector: adds 3 to any digit above 4.
module bin2bcd_add3
    import bin2bcd_pkg::*;
(
    input  logic [3:0] digit_i,
    output logic [3:0] digit_o
);

    assign digit_o = (digit_i > ADD3_THRESH) ? digit_i + ADD3_CORR : digit_i;

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter, one add-3/shift iteration per clock.
// Define BIN2BCD_OVF_EN to add the ovf output and all-nines saturation.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int unsigned BIN_W  = 8,
    parameter int unsigned DIGITS = 3
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [BIN_W-1:0]    bin,
    output logic                busy,
    output logic                done,
`ifdef BIN2BCD_OVF_EN
    output logic                ovf,
`endif
    output logic [4*DIGITS-1:0] bcd
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned SR_W  = BCD_W + BIN_W;
    localparam int unsigned CNT_W = $clog2(BIN_W + 1);

    state_e            state_q;
    logic [BCD_W-1:0]  bcd_acc_q;
    logic [BIN_W-1:0]  bin_acc_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              busy_q;
    logic              done_q;
    logic [BCD_W-1:0]  bcd_q;

    logic [BCD_W-1:0]  bcd_fix;
    logic [SR_W-1:0]   sr_d;
    logic [BCD_W-1:0]  bcd_acc_d;
    logic [BIN_W-1:0]  bin_acc_d;

    for (genvar g = 0; g < DIGITS; g++) begin : g_add3
        bin2bcd_add3 u_add3 (
            .digit_i (bcd_acc_q[4*g +: 4]),
            .digit_o (bcd_fix[4*g +: 4])
        );
    end

    // The top digit's MSB falls off the end, which keeps only the low DIGITS digits.
    always_comb begin
        sr_d      = {bcd_fix, bin_acc_q} << 1;
        bcd_acc_d = sr_d[SR_W-1:BIN_W];
        bin_acc_d = sr_d[BIN_W-1:0];
    end

`ifdef BIN2BCD_OVF_EN
    localparam longint unsigned BCD_MAX = pow10(DIGITS) - 64'd1;
    logic ovf_pend_q;
    logic ovf_q;
`endif

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            bcd_acc_q  <= '0;
            bin_acc_q  <= '0;
            cnt_q      <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            bcd_q      <= '0;
`ifdef BIN2BCD_OVF_EN
            ovf_pend_q <= 1'b0;
            ovf_q      <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (start) begin
                        bcd_acc_q  <= '0;
                        bin_acc_q  <= bin;
                        cnt_q      <= CNT_W'(BIN_W);
                        busy_q     <= 1'b1;
                        state_q    <= SHIFT;
`ifdef BIN2BCD_OVF_EN
                        ovf_pend_q <= (64'(bin) > BCD_MAX);
`endif
                    end
                end
                SHIFT: begin
                    bcd_acc_q <= bcd_acc_d;
                    bin_acc_q <= bin_acc_d;
                    cnt_q     <= cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                        done_q  <= 1'b1;
`ifdef BIN2BCD_OVF_EN
                        ovf_q   <= ovf_pend_q;
                        bcd_q   <= ovf_pend_q ? {DIGITS{BCD_NINE}} : bcd_acc_d;
`else
                        bcd_q   <= bcd_acc_d;
`endif
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign bcd  = bcd_q;
`ifdef BIN2BCD_OVF_EN
    assign ovf  = ovf_q;
`endif

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Directed and sweep bench for bin2bcd_seq; adds a DIGITS=2 overflow
// instance when BIN2BCD_OVF_EN is defined.
module tb_bin2bcd_seq;

    logic        clk;
    logic        rst;
    logic        start;
    logic [7:0]  bin;
    logic        busy;
    logic        done;
    logic [11:0] bcd;
`ifdef BIN2BCD_OVF_EN
    logic        ovf;
    logic        busy2;
    logic        done2;
    logic        ovf2;
    logic [7:0]  bcd2;
`endif

    int total;
    int bad;

    bin2bcd_seq #(.BIN_W(8), .DIGITS(3)) u_dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
`ifdef BIN2BCD_OVF_EN
        .ovf   (ovf),
`endif
        .bcd   (bcd)
    );

`ifdef BIN2BCD_OVF_EN
    bin2bcd_seq #(.BIN_W(8), .DIGITS(2)) u_dut2 (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .bin   (bin),
        .busy  (busy2),
        .done  (done2),
        .ovf   (ovf2),
        .bcd   (bcd2)
    );
`endif

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  v;
        logic [11:0] exp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, got, exp);
        end
    endtask

    function automatic logic [11:0] dec3(input int v);
        return {4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    // Waits for done starting one negedge after the accepting edge; returns edges elapsed.
    task automatic wait_done(output int n);
        n = 0;
        while (done !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
    endtask

    task automatic check_result(input string tag, input logic [7:0] v,
                                input logic [11:0] exp, input int n);
        chk({tag, " latency"}, n, 8);
        chk({tag, " bcd"}, {20'd0, bcd}, {20'd0, exp});
        chk({tag, " busy@done"}, {31'd0, busy}, 0);
`ifdef BIN2BCD_OVF_EN
        chk({tag, " ovf3"}, {31'd0, ovf}, 0);
        chk({tag, " done2"}, {31'd0, done2}, 1);
        chk({tag, " ovf2"}, {31'd0, ovf2}, (v > 8'd99) ? 1 : 0);
        chk({tag, " bcd2"}, {24'd0, bcd2}, (v > 8'd99) ? 32'h99 : {24'd0, exp[7:0]});
`else
        if (v === 8'hxx) chk({tag, " bin"}, 0, 1);
`endif
    endtask

    task automatic run_conv(input string tag, input logic [7:0] v, input logic [11:0] exp);
        int n;
        @(negedge clk);
        bin   = v;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy"}, {31'd0, busy}, 1);
        wait_done(n);
        check_result(tag, v, exp, n);
        @(negedge clk);
        chk({tag, " pulse"}, {31'd0, done}, 0);
    endtask

    initial begin
        int n;
        int stray;
        total = 0;
        bad   = 0;
        start = 1'b0;
        bin   = 8'd0;
        rst   = 1'b1;

        vecs[0]  = '{8'd255, 12'h255};
        vecs[1]  = '{8'd0,   12'h000};
        vecs[2]  = '{8'd99,  12'h099};
        vecs[3]  = '{8'd1,   12'h001};
        vecs[4]  = '{8'd9,   12'h009};
        vecs[5]  = '{8'd10,  12'h010};
        vecs[6]  = '{8'd100, 12'h100};
        vecs[7]  = '{8'd128, 12'h128};
        vecs[8]  = '{8'd199, 12'h199};
        vecs[9]  = '{8'd200, 12'h200};
        vecs[10] = '{8'd254, 12'h254};
        vecs[11] = '{8'd65,  12'h065};

        repeat (3) @(negedge clk);
        chk("reset busy", {31'd0, busy}, 0);
        chk("reset done", {31'd0, done}, 0);
        chk("reset bcd", {20'd0, bcd}, 0);
        rst = 1'b0;
        @(negedge clk);

        for (int i = 0; i < 12; i++) begin
            run_conv($sformatf("vec%0d", i), vecs[i].v, vecs[i].exp);
        end

        // start held through busy: second request accepted right after done
        @(negedge clk);
        bin   = 8'd200;
        start = 1'b1;
        @(negedge clk);
        bin   = 8'd17;
        wait_done(n);
        check_result("hold first", 8'd200, 12'h200, n);
        @(negedge clk);
        start = 1'b0;
        chk("hold second busy", {31'd0, busy}, 1);
        wait_done(n);
        check_result("hold second", 8'd17, 12'h017, n);

        // asynchronous abort mid-conversion
        @(negedge clk);
        bin   = 8'd123;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        chk("abort busy", {31'd0, busy}, 0);
        chk("abort done", {31'd0, done}, 0);
        chk("abort bcd", {20'd0, bcd}, 0);
        @(negedge clk);
        rst = 1'b0;
        stray = 0;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) stray++;
        end
        chk("abort no done", stray, 0);
        chk("abort idle", {31'd0, busy}, 0);

        for (int v = 0; v < 256; v++) begin
            run_conv($sformatf("sweep%0d", v), 8'(v), dec3(v));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
